// File: rtl/emaxi_arb_pkg.sv
// rtl/emaxi_arb_pkg.sv - shared constants and types for the emesh request arbiters
package emaxi_arb_pkg;

  localparam int PW        = 104;
  localparam int MAX_BURST = 4;

  typedef logic [1:0] owner_t;

  // emesh packet field offsets; the arbiter itself never decodes them
  localparam int PKT_WRITE_LSB    = 0;
  localparam int PKT_DATAMODE_LSB = 1;
  localparam int PKT_CTRLMODE_LSB = 3;
  localparam int PKT_DSTADDR_LSB  = 8;
  localparam int PKT_DATA_LSB     = 40;
  localparam int PKT_SRCADDR_LSB  = 72;

  function automatic owner_t next_idx(input owner_t idx, input int n);
    return owner_t'((int'(idx) + 1) % n);
  endfunction

endpackage

// File: rtl/emaxi_wr_arbiter_rr_pick.sv
// rtl/emaxi_wr_arbiter_rr_pick.sv - combinational N-way round-robin picker
// The first requester at or after start (wrapping mod N) wins; gnt is one-hot or zero.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   start,
  output logic [N-1:0] gnt
);

  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && ((int'(start) + k) % N == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/emaxi_wr_arbiter.sv
// rtl/emaxi_wr_arbiter.sv - packet-granular round-robin arbiter for the bridge write port
// Burst ownership is bounded by MAX_BURST; a one-entry output register decouples wr_wait.
module emaxi_wr_arbiter #(
  parameter int N         = 2,
  parameter int PW        = emaxi_arb_pkg::PW,
  parameter int MAX_BURST = emaxi_arb_pkg::MAX_BURST
) (
  input  logic          m_axi_aclk,
  input  logic          m_axi_aresetn,
  input  logic [N-1:0]  req_access,
  input  logic [N*PW-1:0] req_packet,
  output logic [N-1:0]  req_wait,
  output logic          wr_access,
  output logic [PW-1:0] wr_packet,
  input  logic          wr_wait,
  output logic [1:0]    owner,
  output logic          busy
);

  import emaxi_arb_pkg::*;

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  logic          ready_q;
  logic          out_valid;
  logic [PW-1:0] out_pkt;
  owner_t        owner_q;
  logic [3:0]    cnt;

  logic          own_req;
  logic          keep;
  logic          grant_valid;
  logic          slot_free;
  logic          acc;
  owner_t        start;
  owner_t        gidx;
  logic [N-1:0]  own_oh;
  logic [N-1:0]  rr_gnt;
  logic [N-1:0]  gnt;
  logic [PW-1:0] pkt_sel;

  // Owner itself is last in the rotation, so start the search one past it.
  assign start = next_idx(owner_q, N);

  rr_pick #(.N(N)) u_rr_pick (
    .req   (req_access),
    .start (start),
    .gnt   (rr_gnt)
  );

  always_comb begin
    own_req = 1'b0;
    own_oh  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == owner_t'(i)) begin
        own_req   = req_access[i];
        own_oh[i] = 1'b1;
      end
    end
  end

  assign keep        = own_req && (cnt < BURST_CAP);
  assign gnt         = keep ? own_oh : rr_gnt;
  assign grant_valid = |gnt;
  assign slot_free   = ~out_valid | ~wr_wait;
  assign acc         = ready_q & slot_free & grant_valid;

  always_comb begin
    gidx    = '0;
    pkt_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gidx    = owner_t'(i);
        pkt_sel = req_packet[i*PW +: PW];
      end
    end
  end

  assign req_wait = ~(gnt & {N{acc}});

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      ready_q   <= 1'b0;
      out_valid <= 1'b0;
      out_pkt   <= '0;
      owner_q   <= '0;
      cnt       <= '0;
    end else begin
      ready_q <= 1'b1;
      if (acc) begin
        out_pkt   <= pkt_sel;
        out_valid <= 1'b1;
        // A re-pick of the owner after its cap counts as a fresh turn.
        if (keep) begin
          cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
        end else begin
          owner_q <= gidx;
          cnt     <= 4'd1;
        end
      end else if (!wr_wait) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign wr_access = out_valid;
  assign wr_packet = out_pkt;
  assign busy      = out_valid;
  assign owner     = owner_q;

endmodule

// File: tb/tb_emaxi_wr_arbiter.sv
// tb/tb_emaxi_wr_arbiter.sv - randomized self-checking bench for emaxi_wr_arbiter
module tb_emaxi_wr_arbiter;

  localparam int N  = 3;
  localparam int PW = 104;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_access;
  logic [N*PW-1:0] req_packet;
  logic [N-1:0]    req_wait;
  logic            wr_access;
  logic [PW-1:0]   wr_packet;
  logic            wr_wait;
  logic [1:0]      owner;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  int            m_owner;
  int            m_cnt;
  bit            m_valid;
  bit            m_ready;
  logic [PW-1:0] m_pkt;
  bit            force_a5 = 1'b0;
  logic [PW-1:0] a5_pkt;

  always #5 clk = ~clk;

  emaxi_wr_arbiter #(.N(N), .PW(PW), .MAX_BURST(MB)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .req_access    (req_access),
    .req_packet    (req_packet),
    .req_wait      (req_wait),
    .wr_access     (wr_access),
    .wr_packet     (wr_packet),
    .wr_wait       (wr_wait),
    .owner         (owner),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pkt();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_ready = 1'b0;
    m_pkt   = '0;
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".wr_access"}, 128'(wr_access), 128'(m_valid));
    check({ph, ".busy"},      128'(busy),      128'(m_valid));
    check({ph, ".wr_packet"}, 128'(wr_packet), 128'(m_pkt));
    check({ph, ".owner"},     128'(owner),     128'(m_owner));
  endtask

  // One cycle: drive sources, predict the grant from the round-robin rules, clock, compare.
  task automatic step(input string ph, input logic [N-1:0] a, input logic ww);
    logic [PW-1:0] p [N];
    logic [N-1:0]  ew;
    logic [1:0]    oi;
    int            g;
    bit            kept;
    bit            acc;
    req_access = a;
    wr_wait    = ww;
    for (int i = 0; i < N; i++) begin
      p[i] = rnd_pkt();
      if (i == 0 && force_a5) p[i] = a5_pkt;
      req_packet[i*PW +: PW] = p[i];
    end
    g    = -1;
    kept = 1'b0;
    oi   = 2'(m_owner);
    if (a[oi] && m_cnt < MB) begin
      g    = m_owner;
      kept = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_owner + k) % N;
        if (g < 0 && a[2'(s)]) g = s;
      end
    end
    acc = m_ready && (!m_valid || !ww) && (g >= 0);
    ew  = '1;
    if (acc) ew[2'(g)] = 1'b0;
    #1;
    check({ph, ".req_wait"}, 128'(req_wait), 128'(ew));
    @(posedge clk);
    #1;
    if (acc) begin
      m_pkt   = p[2'(g)];
      m_valid = 1'b1;
      if (kept) begin
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end else begin
        m_owner = g;
        m_cnt   = 1;
      end
    end else if (!ww) begin
      m_valid = 1'b0;
    end
    m_ready = 1'b1;
    check_outputs(ph);
  endtask

  initial begin
    logic [127:0] a5_wide;
    a5_wide    = {16{8'hA5}};
    a5_pkt     = a5_wide[PW-1:0];
    rst_n      = 1'b0;
    req_access = '0;
    req_packet = '0;
    wr_wait    = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.req_wait", 128'(req_wait), 128'({N{1'b1}}));

    rst_n    = 1'b1;
    force_a5 = 1'b1;
    step("first", 3'b001, 1'b0);
    step("first", 3'b001, 1'b0);
    check("first.a5_packet", 128'(wr_packet), 128'(a5_pkt));
    force_a5 = 1'b0;

    repeat (16) step("alt", 3'b011, 1'b0);
    repeat (10) step("solo1", 3'b010, 1'b0);
    repeat (3)  step("stall", 3'b011, 1'b1);
    repeat (2)  step("unstall", 3'b011, 1'b0);
    repeat (2)  step("own0", 3'b001, 1'b0);
    step("drop0", 3'b010, 1'b0);
    check("drop0.owner_is_1", 128'(owner), 128'(1));

    repeat (300) step("rand", 3'($urandom), 1'($urandom_range(0, 3) == 0));

    step("pre_rst", 3'b001, 1'b0);
    check("pre_rst.wr_access", 128'(wr_access), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.req_wait", 128'(req_wait), 128'({N{1'b1}}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) step("post_rst", 3'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
